// File: rtl/mc6845_pkg.sv
// Shared definitions for the MC6845 init sequencer: register indices, state
// encodings and the power-up register table.
package mc6845_pkg;

    localparam logic [4:0] R_HTOTAL       = 5'd0;
    localparam logic [4:0] R_HDISP        = 5'd1;
    localparam logic [4:0] R_HSYNC_POS    = 5'd2;
    localparam logic [4:0] R_SYNC_WIDTH   = 5'd3;
    localparam logic [4:0] R_VTOTAL       = 5'd4;
    localparam logic [4:0] R_VTOTAL_ADJ   = 5'd5;
    localparam logic [4:0] R_VDISP        = 5'd6;
    localparam logic [4:0] R_VSYNC_POS    = 5'd7;
    localparam logic [4:0] R_INTERLACE    = 5'd8;
    localparam logic [4:0] R_MAX_SCAN     = 5'd9;
    localparam logic [4:0] R_CURSOR_START = 5'd10;
    localparam logic [4:0] R_CURSOR_END   = 5'd11;
    localparam logic [4:0] R_START_H      = 5'd12;
    localparam logic [4:0] R_START_L      = 5'd13;
    localparam logic [4:0] R_CURSOR_H     = 5'd14;
    localparam logic [4:0] R_CURSOR_L     = 5'd15;
    localparam logic [4:0] R_LPEN_H       = 5'd16;
    localparam logic [4:0] R_LPEN_L       = 5'd17;

    localparam int NUM_INIT_REGS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_VERIFY,
        ST_CUR,
        ST_DONE
    } seq_state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_EHI,
        PH_ELO
    } bus_phase_e;

    function automatic logic [7:0] reg_default(input logic [4:0] idx);
        case (idx)
            R_HTOTAL:     return 8'h5e;
            R_HDISP:      return 8'h4c;
            R_HSYNC_POS:  return 8'h4e;
            R_SYNC_WIDTH: return 8'h0c;
            R_VTOTAL:     return 8'h40;
            R_VTOTAL_ADJ: return 8'h05;
            R_VDISP:      return 8'h3c;
            R_VSYNC_POS:  return 8'h3d;
            R_MAX_SCAN:   return 8'h07;
            default:      return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/mc6845_init_sequencer_if.sv
// CRTC host-bus pins (CSn, E, RS, RW, D) seen from the bus master and from the CRTC.
interface mc6845_init_sequencer_if;
    logic       CSn;
    logic       E;
    logic       RS;
    logic       RW;
    logic [7:0] D_out;
    logic       D_oe;
    logic [7:0] D_in;

    modport master (output CSn, E, RS, RW, D_out, D_oe, input D_in);
    modport slave  (input CSn, E, RS, RW, D_out, D_oe, output D_in);
endinterface

// File: rtl/mc6845_init_sequencer_bus.sv
// One CRTC bus access: SETUP, E_CYCLES of E high, E_CYCLES of E low.
// A new go on the final ELO cycle chains the next access with CSn held low.
module mc6845_bus_access
    import mc6845_pkg::*;
#(
    parameter int E_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       go,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       last,
    output logic       last_next,
    output logic       csn,
    output logic       e,
    output logic       rs_pin,
    output logic       rw_pin,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic [7:0] d_in
);

    localparam int            CW      = (E_CYCLES > 1) ? $clog2(E_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_END = CW'(E_CYCLES - 1);

    bus_phase_e    phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          csn_q, csn_d, e_q, e_d, rs_q, rs_d, rw_q, rw_d, doe_q, doe_d;
    logic          last_q, last_d;
    logic [7:0]    dout_q, dout_d, rdata_q, rdata_d;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        csn_d   = csn_q;
        e_d     = e_q;
        rs_d    = rs_q;
        rw_d    = rw_q;
        dout_d  = dout_q;
        doe_d   = doe_q;
        rdata_d = rdata_q;
        last_d  = 1'b0;
        unique case (phase_q)
            PH_SETUP: begin
                phase_d = PH_EHI;
                cnt_d   = '0;
                e_d     = 1'b1;
            end
            PH_EHI: begin
                if (cnt_q == CNT_END) begin
                    // Read data is taken while E is still high.
                    phase_d = PH_ELO;
                    cnt_d   = '0;
                    e_d     = 1'b0;
                    rdata_d = d_in;
                    last_d  = (E_CYCLES == 1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PH_ELO: begin
                if (cnt_q != CNT_END) begin
                    cnt_d  = cnt_q + 1'b1;
                    last_d = ((cnt_q + 1'b1) == CNT_END);
                end else begin
                    phase_d = PH_IDLE;
                    csn_d   = 1'b1;
                    rs_d    = 1'b0;
                    rw_d    = 1'b1;
                    dout_d  = 8'h00;
                    doe_d   = 1'b0;
                end
            end
            default: ;
        endcase
        if (go && ((phase_q == PH_IDLE) || last_q)) begin
            phase_d = PH_SETUP;
            cnt_d   = '0;
            csn_d   = 1'b0;
            e_d     = 1'b0;
            rs_d    = rs;
            rw_d    = rw;
            dout_d  = rw ? 8'h00 : wdata;
            doe_d   = !rw;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            csn_q   <= 1'b1;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            rw_q    <= 1'b1;
            dout_q  <= 8'h00;
            doe_q   <= 1'b0;
            last_q  <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            csn_q   <= csn_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            rw_q    <= rw_d;
            dout_q  <= dout_d;
            doe_q   <= doe_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign last      = last_q;
    assign last_next = last_d;
    assign csn       = csn_q;
    assign e         = e_q;
    assign rs_pin    = rs_q;
    assign rw_pin    = rw_q;
    assign d_out     = dout_q;
    assign d_oe      = doe_q;

endmodule

// File: rtl/mc6845_init_sequencer.sv
// MC6845 host-bus master: loads R0..R15 from the default table, reads back
// R14/R15, then arbitrates the bus for cursor-position updates.
module mc6845_init_sequencer
    import mc6845_pkg::*;
#(
    parameter int E_CYCLES   = 2,
    parameter int AUTO_START = 1
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic                     start,
    input  logic                     cursor_req,
    input  logic [13:0]              cursor_addr,
    output logic                     cursor_ack,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    mc6845_init_sequencer_if.master  crtc
);

    localparam logic [4:0] INIT_LAST_OP = 5'(2 * NUM_INIT_REGS - 1);
    localparam logic [4:0] PAIR_LAST_OP = 5'd3;

    seq_state_e  state_q, state_d;
    logic [4:0]  op_q, op_d;
    logic        done_q, done_d, error_q, error_d, mism_q, mism_d;
    logic        auto_q, auto_d, busy_q, busy_d, ack_q, ack_d;
    logic [13:0] cur_addr_q, cur_addr_d;

    logic        go, launch_init, launch_cur;
    logic        acc_rs, acc_rw;
    logic [4:0]  acc_reg;
    logic [7:0]  acc_wdata, r14_def, verify_exp;
    logic [7:0]  bus_rdata;
    logic        bus_last, bus_last_next;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        done_d      = done_q;
        error_d     = error_q;
        mism_d      = mism_q;
        cur_addr_d  = cur_addr_q;
        auto_d      = 1'b0;
        go          = 1'b0;
        launch_init = 1'b0;
        launch_cur  = 1'b0;
        r14_def     = reg_default(R_CURSOR_H);
        // R14 only implements six bits, so only those are expected back.
        verify_exp  = op_q[1] ? reg_default(R_CURSOR_L) : {2'b00, r14_def[5:0]};

        unique case (state_q)
            ST_IDLE: launch_init = start || auto_q;
            ST_INIT: begin
                if (bus_last) begin
                    go = 1'b1;
                    if (op_q == INIT_LAST_OP) begin
                        state_d = ST_VERIFY;
                        op_d    = '0;
                    end else begin
                        op_d = op_q + 5'd1;
                    end
                end
            end
            ST_VERIFY: begin
                if (bus_last) begin
                    if (op_q[0] && (bus_rdata != verify_exp)) begin
                        mism_d = 1'b1;
                    end
                    if (op_q == PAIR_LAST_OP) begin
                        done_d  = !mism_d;
                        error_d = mism_d;
                        // A request held through init is served without dropping busy.
                        if (!mism_d && cursor_req) begin
                            launch_cur = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        op_d = op_q + 5'd1;
                        go   = 1'b1;
                    end
                end
            end
            ST_CUR: begin
                if (bus_last) begin
                    if (op_q == PAIR_LAST_OP) begin
                        state_d = ST_DONE;
                    end else begin
                        op_d = op_q + 5'd1;
                        go   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    launch_init = 1'b1;
                end else if (cursor_req && done_q) begin
                    launch_cur = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (launch_init) begin
            state_d = ST_INIT;
            op_d    = '0;
            go      = 1'b1;
            done_d  = 1'b0;
            error_d = 1'b0;
            mism_d  = 1'b0;
        end
        if (launch_cur) begin
            state_d    = ST_CUR;
            op_d       = '0;
            go         = 1'b1;
            cur_addr_d = cursor_addr;
        end

        // Fields for the access issued this cycle, derived from the next op.
        acc_reg = (state_d == ST_INIT) ? {1'b0, op_d[4:1]}
                                       : (op_d[1] ? R_CURSOR_L : R_CURSOR_H);
        acc_rs  = op_d[0];
        acc_rw  = (state_d == ST_VERIFY) && op_d[0];
        if (!op_d[0]) begin
            acc_wdata = {3'b000, acc_reg};
        end else if (state_d == ST_CUR) begin
            acc_wdata = op_d[1] ? cur_addr_d[7:0] : {2'b00, cur_addr_d[13:8]};
        end else begin
            acc_wdata = reg_default(acc_reg);
        end

        busy_d = (state_d == ST_INIT) || (state_d == ST_VERIFY) || (state_d == ST_CUR);
        ack_d  = (state_q == ST_CUR) && (op_q == PAIR_LAST_OP) && bus_last_next;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            mism_q     <= 1'b0;
            cur_addr_q <= '0;
            auto_q     <= (AUTO_START != 0);
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            done_q     <= done_d;
            error_q    <= error_d;
            mism_q     <= mism_d;
            cur_addr_q <= cur_addr_d;
            auto_q     <= auto_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
        end
    end

    mc6845_bus_access #(
        .E_CYCLES (E_CYCLES)
    ) u_bus (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .go        (go),
        .rs        (acc_rs),
        .rw        (acc_rw),
        .wdata     (acc_wdata),
        .rdata     (bus_rdata),
        .last      (bus_last),
        .last_next (bus_last_next),
        .csn       (crtc.CSn),
        .e         (crtc.E),
        .rs_pin    (crtc.RS),
        .rw_pin    (crtc.RW),
        .d_out     (crtc.D_out),
        .d_oe      (crtc.D_oe),
        .d_in      (crtc.D_in)
    );

    assign cursor_ack = ack_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_mc6845_init_sequencer.sv
// Directed bench: a small MC6845 model logs every bus transfer, which is compared
// against a hand-written table of the expected init/verify/cursor accesses.
module tb_mc6845_init_sequencer;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        start = 1'b0;
    logic        cursor_req = 1'b0;
    logic [13:0] cursor_addr = 14'h0;
    logic        cursor_ack, busy, done, error;

    mc6845_init_sequencer_if crtc_if ();

    mc6845_init_sequencer #(.E_CYCLES(2), .AUTO_START(1)) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .start       (start),
        .cursor_req  (cursor_req),
        .cursor_addr (cursor_addr),
        .cursor_ack  (cursor_ack),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .crtc        (crtc_if)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // ---------------- CRTC model and bus log ----------------
    logic [7:0] mregs [0:31];
    logic [4:0] maddr = 5'd0;
    logic       force_r14 = 1'b0;
    logic       e_prev = 1'b0;
    int         cyc = 0;
    int         rise_cyc = 0;
    int         log_n = 0;
    logic       log_rs [0:511];
    logic       log_rw [0:511];
    logic [7:0] log_d [0:511];
    int         log_fall [0:511];
    int         log_rise [0:511];
    int         ack_cnt = 0;
    int         ack_cyc = 0;
    int         prop_bad = 0;

    assign crtc_if.D_in = (!crtc_if.CSn && crtc_if.RS && crtc_if.RW)
                          ? ((force_r14 && maddr == 5'd14) ? 8'h3f : mregs[maddr]) : 8'h00;

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            e_prev <= 1'b0;
            cyc    <= 0;
        end else begin
            cyc    <= cyc + 1;
            e_prev <= crtc_if.E;
            if (!e_prev && crtc_if.E) rise_cyc <= cyc;
            if (e_prev && !crtc_if.E && !crtc_if.CSn && log_n < 512) begin
                if (!crtc_if.RS && !crtc_if.RW) maddr <= crtc_if.D_out[4:0];
                if (crtc_if.RS && !crtc_if.RW) mregs[maddr] <= crtc_if.D_out;
                log_rs[log_n]   <= crtc_if.RS;
                log_rw[log_n]   <= crtc_if.RW;
                log_d[log_n]    <= crtc_if.RW ? crtc_if.D_in : crtc_if.D_out;
                log_fall[log_n] <= cyc;
                log_rise[log_n] <= rise_cyc;
                log_n           <= log_n + 1;
            end
            if (cursor_ack) begin
                ack_cnt <= ack_cnt + 1;
                ack_cyc <= cyc;
            end
            if (busy != !crtc_if.CSn) prop_bad <= prop_bad + 1;
            if ((!crtc_if.CSn && crtc_if.D_oe != !crtc_if.RW) || (crtc_if.CSn && crtc_if.D_oe))
                prop_bad <= prop_bad + 1;
        end
    end

    // ---------------- expected access table ----------------
    typedef struct {
        logic       rs;
        logic       rw;
        logic [7:0] d;
        int         fall;
        int         width;
    } xfer_t;

    xfer_t      exp_tab [0:35];
    logic [7:0] init_vals [0:15];
    int         idle_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s act=%h exp=%h (cyc=%0d)", name, act, expv, cyc);
        end
    endtask

    task automatic wait_to(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 4000) begin
            @(negedge CLK);
            guard++;
            if (cursor_ack) cursor_req = 1'b0;
            if (!busy) idle_cnt++;
        end
        if (guard >= 4000) chk("wait_bound", 32'(cyc), 32'(n));
    endtask

    task automatic check_reset_vec(input string name);
        chk(name, {15'b0, crtc_if.CSn, crtc_if.E, crtc_if.RS, crtc_if.RW, crtc_if.D_out,
                   crtc_if.D_oe, busy, done, error, cursor_ack},
            {15'b0, 17'b1_0_0_1_00000000_0_0_0_0_0});
    endtask

    task automatic check_init_log(input int lb, input int s);
        for (int k = 0; k < 36; k++) begin
            chk($sformatf("xfer%0d", k), {23'b0, log_rs[lb+k], log_rw[lb+k], log_d[lb+k]},
                {23'b0, exp_tab[k].rs, exp_tab[k].rw, exp_tab[k].d});
            chk($sformatf("fall%0d", k), 32'(log_fall[lb+k]), 32'(s + exp_tab[k].fall));
            chk($sformatf("ehi_w%0d", k), 32'(log_fall[lb+k] - log_rise[lb+k]), 32'(exp_tab[k].width));
        end
    endtask

    task automatic check_cursor_log(input int lb, input int c, input logic [13:0] a);
        logic [7:0] ed [0:3];
        ed[0] = 8'h0e;
        ed[1] = {2'b00, a[13:8]};
        ed[2] = 8'h0f;
        ed[3] = a[7:0];
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cur_xfer%0d", k), {23'b0, log_rs[lb+k], log_rw[lb+k], log_d[lb+k]},
                {23'b0, 1'(k % 2), 1'b0, ed[k]});
            chk($sformatf("cur_fall%0d", k), 32'(log_fall[lb+k]), 32'(c + 4 + 5 * k));
        end
        $display("cursor xfer addr=%h accepted at cyc=%0d", a, c);
    endtask

    // Init from start cycle s; optional cursor request raised at cycle s+req_off.
    task automatic run_init(input int s, input int lb, input bit with_cur,
                            input int req_off, input logic [13:0] a);
        int ab;
        ab = ack_cnt;
        idle_cnt = 0;
        if (with_cur && req_off > 0) begin
            wait_to(s + req_off);
            cursor_req  = 1'b1;
            cursor_addr = a;
        end
        wait_to(s + 180);
        chk("done_before_181", 32'(done), 32'd0);
        chk("busy_during_init", 32'(idle_cnt), 32'd0);
        wait_to(s + 181);
        chk("done_at_181", 32'(done), 32'd1);
        chk("error_at_181", 32'(error), 32'd0);
        chk("busy_at_181", 32'(busy), 32'(with_cur));
        check_init_log(lb, s);
        $display("init run from cyc=%0d logged", s);
        if (with_cur) begin
            idle_cnt = 0;
            wait_to(s + 200);
            chk("busy_through_cursor", 32'(idle_cnt), 32'd0);
            wait_to(s + 215);
            chk("ack_count", 32'(ack_cnt - ab), 32'd1);
            chk("ack_cycle", 32'(ack_cyc), 32'(s + 200));
            check_cursor_log(lb + 36, s + 180, a);
            chk("busy_after_cursor", 32'(busy), 32'd0);
        end
    endtask

    task automatic pulse_start(output int s, output int lb);
        @(negedge CLK);
        s     = cyc;
        lb    = log_n;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk("done_cleared_by_start", 32'(done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int s, lb, c, ab;
        init_vals = '{8'h5e, 8'h4c, 8'h4e, 8'h0c, 8'h40, 8'h05, 8'h3c, 8'h3d,
                      8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int r = 0; r < 16; r++) begin
            exp_tab[2*r]   = '{rs: 1'b0, rw: 1'b0, d: 8'(r), fall: 4 + 10*r, width: 2};
            exp_tab[2*r+1] = '{rs: 1'b1, rw: 1'b0, d: init_vals[r], fall: 9 + 10*r, width: 2};
        end
        exp_tab[32] = '{rs: 1'b0, rw: 1'b0, d: 8'h0e, fall: 164, width: 2};
        exp_tab[33] = '{rs: 1'b1, rw: 1'b1, d: 8'h00, fall: 169, width: 2};
        exp_tab[34] = '{rs: 1'b0, rw: 1'b0, d: 8'h0f, fall: 174, width: 2};
        exp_tab[35] = '{rs: 1'b1, rw: 1'b1, d: 8'h00, fall: 179, width: 2};

        // Reset values, then auto-start on release.
        repeat (3) @(negedge CLK);
        check_reset_vec("reset_state");
        lb = log_n;
        RSTn = 1'b1;
        run_init(0, lb, 1'b0, 0, 14'h0);

        // Cursor update after done; address change after acceptance is ignored.
        @(negedge CLK);
        c  = cyc;
        lb = log_n;
        ab = ack_cnt;
        cursor_req  = 1'b1;
        cursor_addr = 14'h3aad;
        @(negedge CLK);
        cursor_addr = 14'h1111;
        wait_to(c + 30);
        chk("cur_ack_count", 32'(ack_cnt - ab), 32'd1);
        chk("cur_ack_cycle", 32'(ack_cyc), 32'(c + 20));
        chk("cur_done_kept", 32'(done), 32'd1);
        check_cursor_log(lb, c, 14'h3aad);

        // Request raised at cycle 50 of a re-init.
        pulse_start(s, lb);
        run_init(s, lb, 1'b1, 50, 14'h0123);

        // start and cursor_req in the same DONE cycle: start wins.
        @(negedge CLK);
        s  = cyc;
        lb = log_n;
        start       = 1'b1;
        cursor_req  = 1'b1;
        cursor_addr = 14'h2c7e;
        @(negedge CLK);
        start = 1'b0;
        chk("collide_done_low", 32'(done), 32'd0);
        chk("collide_no_early_ack", 32'(cursor_ack), 32'd0);
        run_init(s, lb, 1'b1, 0, 14'h2c7e);

        // Verify mismatch: error set, cursor requests never acknowledged.
        force_r14 = 1'b1;
        pulse_start(s, lb);
        wait_to(s + 181);
        chk("err_error", 32'(error), 32'd1);
        chk("err_done", 32'(done), 32'd0);
        force_r14 = 1'b0;
        ab = ack_cnt;
        lb = log_n;
        cursor_req  = 1'b1;
        cursor_addr = 14'h0555;
        wait_to(s + 1181);
        chk("err_no_ack", 32'(ack_cnt - ab), 32'd0);
        chk("err_no_bus", 32'(log_n - lb), 32'd0);
        chk("err_idle", 32'(busy), 32'd0);
        cursor_req = 1'b0;
        $display("error run from cyc=%0d checked", s);

        // Reset during EHI of the R7 data write aborts at once; init restarts at R0.
        pulse_start(s, lb);
        chk("err_cleared_by_start", 32'(error), 32'd0);
        wait_to(s + 77);
        chk("r7_ehi_e", {23'b0, crtc_if.E, crtc_if.RS, crtc_if.D_out}, {23'b0, 1'b1, 1'b1, 8'h3d});
        RSTn = 1'b0;
        #1;
        chk("abort_e_csn", {30'b0, crtc_if.E, crtc_if.CSn}, {30'b0, 1'b0, 1'b1});
        check_reset_vec("abort_state");
        @(negedge CLK);
        lb = log_n;
        RSTn = 1'b1;
        run_init(0, lb, 1'b0, 0, 14'h0);

        chk("bus_properties", 32'(prop_bad), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc6845_init_sequencer.md
Name: mc6845_init_sequencer

Overview:
- Host-bus master for the MC6845 CRTC register interface (CSn, E, RS, RW, D).
- After reset, or on a start pulse, it programs CRTC registers R0–R15 from a constant table.
- It then reads back R14/R15 to confirm the bus works.
- After init completes, it shares the same bus with a cursor-update requester, so software or a text engine can move the cursor without driving the CRTC directly.
- Sits between the system core and the MC6845 instance. Runs entirely on the CRTC character clock domain.

Parameters:
- E_CYCLES, 2, CLK cycles E is held high and then low per bus access (each ≥1).
- AUTO_START, 1, when 1 an init sequence begins automatically on the first cycle after RSTn deasserts.

Ports:
- CLK  in  1  single clock; all state changes on rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins an init sequence; ignored while busy.
- cursor_req  in  1  level request to write cursor_addr into R14/R15; held until cursor_ack.
- cursor_addr  in  14  new cursor address; sampled when the request is accepted.
- cursor_ack  out  1  one-cycle pulse after the R15 write completes.
- busy  out  1  high while any bus sequence is in progress.
- done  out  1  high once init plus verify has completed successfully; cleared by start.
- error  out  1  high if the verify read mismatched; cleared by start.
- CSn  out  1  CRTC chip select, active low.
- E  out  1  CRTC enable strobe; data transfers on its falling edge.
- RS  out  1  0 = address register, 1 = data register.
- RW  out  1  0 = write, 1 = read.
- D_out  out  8  write data.
- D_oe  out  1  drive enable for D_out; equals !RW during an access, else 0.
- D_in  in  8  read data from the D bus.

Behaviour:
- Reset values: CSn=1, E=0, RS=0, RW=1, D_out=0, D_oe=0, busy=0, done=0, error=0, cursor_ack=0. State=IDLE. A pending request is dropped.
- Reset mid-operation aborts immediately; outputs return to reset values within the same cycle.
- Bus access micro-sequence, 1+2·E_CYCLES cycles:
  - SETUP, 1 cycle: CSn=0, RS/RW/D_out valid, E=0.
  - EHI, E_CYCLES cycles: E=1.
  - ELO, E_CYCLES cycles: E=0.
  - RS, RW, D_out and CSn stay stable through the whole access.
  - CSn returns to 1 only in IDLE/DONE.
- Read data: D_in is captured on the last EHI cycle.
- Each register operation is two accesses:
  - write register: address access (RS=0, RW=0, D_out={3'b0,reg}), then data access (RS=1, RW=0).
  - read register: address access, then read access (RS=1, RW=1, D_oe=0).
- Main FSM states:
  - IDLE → INIT on start, or automatically after reset if AUTO_START.
  - INIT writes R0..R15 in ascending order, then goes to VERIFY.
  - VERIFY reads R14, then R15, and compares against the table: {2'b0,R14[5:0]} and R15.
  - Match → DONE with done=1. Mismatch → DONE with error=1, done=0.
  - In DONE: start → INIT (clears done/error); else cursor_req → CUR.
  - CUR writes R14 = {2'b0,cursor_addr[13:8]}, then R15 = cursor_addr[7:0]. It pulses cursor_ack on the last ELO cycle of the R15 write, then returns to DONE.
- Priority and boundary rules:
  - start and cursor_req in the same DONE cycle: start wins; cursor_req stays pending.
  - cursor_req during INIT/VERIFY stays pending and is served on entry to DONE, but only if done=1.
  - While error=1, cursor_req is never acknowledged.
  - start during INIT/VERIFY/CUR is ignored.
  - cursor_addr is latched at CUR entry; later changes have no effect.
- busy is 1 in INIT/VERIFY/CUR and 0 in IDLE/DONE.
- Latency with E_CYCLES=2:
  - init: 32 accesses × 5 = 160 cycles.
  - verify: 20 cycles.
  - done rises 181 cycles after the start pulse.
  - cursor update: 20 cycles from acceptance to ack.
- Table contents, R0–R15: 5e 4c 4e 0c 40 05 3c 3d 00 07 00 00 00 00 00 00.

Decomposition:
- Shared package mc6845_pkg holds:
  - register index constants R_HTOTAL..R_CURSOR_L, plus R_LPEN_H and R_LPEN_L.
  - NUM_INIT_REGS=16.
  - FSM state encodings.
  - the reset table as a function reg_default(idx).
- One sub-module, mc6845_bus_access, implements the SETUP/EHI/ELO micro-sequence:
  - inputs: go, rs, rw, wdata.
  - outputs: rdata, last (asserted on the final ELO cycle), plus the pin drivers.

Test Plan:
- Reset, AUTO_START=1, E_CYCLES=2 → 32 accesses on the bus:
  - the access pair for R1 shows D=01 then D=4c, each with E high for exactly 2 cycles.
  - done=1 and error=0 at cycle 181.
- MC6845 model forced to return 0x3f for R14 → error=1, done=0. A following cursor_req gets no ack within 1000 cycles.
- After done, cursor_req with cursor_addr=0x3aad → R14 write D=3a, R15 write D=ad. cursor_ack pulses once, 20 cycles after acceptance.
- cursor_req asserted at cycle 50 of init, cursor_addr=0x0123 → init continues unchanged. The cursor write starts on the first DONE cycle and busy stays 1 throughout.
- start and cursor_req in the same DONE cycle → re-init runs first with done=0 during it. The cursor is written after the new done and acked.
- RSTn pulsed low during the EHI of R7's data write → E=0 and CSn=1 in the same cycle. After release, init restarts from R0.
